// File: rtl/cmp_result_window.sv
// Windowed monitor for comparator G/E/L results: per-window class/error counts, longest run, majority.
// Latency: out_valid rises the cycle after the edge that accepts the WINDOW-th sample; IDLE->COLLECT takes 1 cycle.
// Backpressure: in_ready is low outside COLLECT; the summary is held in REPORT until out_valid && out_ready.
module cmp_result_window #(
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             G,
    input  logic             E,
    input  logic             L,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_g,
    output logic [CNT_W-1:0] cnt_e,
    output logic [CNT_W-1:0] cnt_l,
    output logic [CNT_W-1:0] cnt_err,
    output logic [CNT_W-1:0] max_run,
    output logic [1:0]       majority
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    // Class encoding shared by prev tracking and the majority output.
    localparam logic [1:0]       CLS_NONE = 2'b00;
    localparam logic [1:0]       CLS_G    = 2'b01;
    localparam logic [1:0]       CLS_E    = 2'b10;
    localparam logic [1:0]       CLS_L    = 2'b11;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_g_q, cnt_g_d;
    logic [CNT_W-1:0] cnt_e_q, cnt_e_d;
    logic [CNT_W-1:0] cnt_l_q, cnt_l_d;
    logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
    logic [CNT_W-1:0] cur_run_q, cur_run_d;
    logic [CNT_W-1:0] max_run_q, max_run_d;
    logic [CNT_W-1:0] n_acc_q, n_acc_d;
    logic [1:0]       prev_q, prev_d;

    logic [1:0]       cls;
    logic             cls_ok;
    logic [CNT_W-1:0] run_new;
    logic             clr;

    // Decode the comparator triple; anything other than exactly one hot bit is malformed.
    always_comb begin
        cls    = CLS_NONE;
        cls_ok = 1'b0;
        case ({G, E, L})
            3'b100: begin cls = CLS_G; cls_ok = 1'b1; end
            3'b010: begin cls = CLS_E; cls_ok = 1'b1; end
            3'b001: begin cls = CLS_L; cls_ok = 1'b1; end
            default: begin cls = CLS_NONE; cls_ok = 1'b0; end
        endcase
        // prev is CLS_NONE after an error or window start, so it never matches a valid class.
        if (cls_ok && (prev_q == cls)) begin
            run_new = cur_run_q + ONE;
        end else if (cls_ok) begin
            run_new = ONE;
        end else begin
            run_new = '0;
        end
    end

    // Next-state and window datapath; clr wipes all window state on window start and handshake.
    always_comb begin
        state_d   = state_q;
        cnt_g_d   = cnt_g_q;
        cnt_e_d   = cnt_e_q;
        cnt_l_d   = cnt_l_q;
        cnt_err_d = cnt_err_q;
        cur_run_d = cur_run_q;
        max_run_d = max_run_q;
        n_acc_d   = n_acc_q;
        prev_d    = prev_q;
        clr       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_COLLECT;
                    clr     = 1'b1;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    if (cls_ok) begin
                        case (cls)
                            CLS_G:   cnt_g_d = cnt_g_q + ONE;
                            CLS_E:   cnt_e_d = cnt_e_q + ONE;
                            default: cnt_l_d = cnt_l_q + ONE;
                        endcase
                    end else begin
                        cnt_err_d = cnt_err_q + ONE;
                    end
                    cur_run_d = run_new;
                    prev_d    = cls;
                    if (run_new > max_run_q) begin
                        max_run_d = run_new;
                    end
                    n_acc_d = n_acc_q + ONE;
                    if (n_acc_q == LAST_IDX) begin
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (out_ready) begin
                    clr     = 1'b1;
                    state_d = en ? S_COLLECT : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                clr     = 1'b1;
            end
        endcase

        if (clr) begin
            cnt_g_d   = '0;
            cnt_e_d   = '0;
            cnt_l_d   = '0;
            cnt_err_d = '0;
            cur_run_d = '0;
            max_run_d = '0;
            n_acc_d   = '0;
            prev_d    = CLS_NONE;
        end
    end

    // State and window registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_g_q   <= '0;
            cnt_e_q   <= '0;
            cnt_l_q   <= '0;
            cnt_err_q <= '0;
            cur_run_q <= '0;
            max_run_q <= '0;
            n_acc_q   <= '0;
            prev_q    <= CLS_NONE;
        end else begin
            state_q   <= state_d;
            cnt_g_q   <= cnt_g_d;
            cnt_e_q   <= cnt_e_d;
            cnt_l_q   <= cnt_l_d;
            cnt_err_q <= cnt_err_d;
            cur_run_q <= cur_run_d;
            max_run_q <= max_run_d;
            n_acc_q   <= n_acc_d;
            prev_q    <= prev_d;
        end
    end

    // Majority needs a strict winner; ties at the top and an empty window both give 00.
    always_comb begin
        majority = CLS_NONE;
        if ((cnt_g_q > cnt_e_q) && (cnt_g_q > cnt_l_q)) begin
            majority = CLS_G;
        end else if ((cnt_e_q > cnt_g_q) && (cnt_e_q > cnt_l_q)) begin
            majority = CLS_E;
        end else if ((cnt_l_q > cnt_g_q) && (cnt_l_q > cnt_e_q)) begin
            majority = CLS_L;
        end
    end

    // Handshake flags are pure state decodes, so no input reaches them combinationally.
    assign in_ready  = (state_q == S_COLLECT);
    assign out_valid = (state_q == S_REPORT);
    assign cnt_g     = cnt_g_q;
    assign cnt_e     = cnt_e_q;
    assign cnt_l     = cnt_l_q;
    assign cnt_err   = cnt_err_q;
    assign max_run   = max_run_q;

endmodule

// File: tb/tb_cmp_result_window.sv
// Directed bench for cmp_result_window: table of full windows plus reset/backpressure/en sequences.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same offset.
// Every comparison goes through check(); the summary prints the counts it maintains.
module tb_cmp_result_window;

    localparam int WINDOW = 8;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic             G, E, L;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] cnt_g, cnt_e, cnt_l, cnt_err, max_run;
    logic [1:0]       majority;

    int n_checks = 0;
    int n_fail   = 0;

    cmp_result_window #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .G         (G),
        .E         (E),
        .L         (L),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_g     (cnt_g),
        .cnt_e     (cnt_e),
        .cnt_l     (cnt_l),
        .cnt_err   (cnt_err),
        .max_run   (max_run),
        .majority  (majority)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:7][2:0] smp;   // {G,E,L} per sample, in arrival order
        int g, e, l, err, run, maj;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] gel);
        in_valid  = 1'b1;
        {G, E, L} = gel;
        step();
    endtask

    task automatic check_summary(input string tag, input int g, input int e, input int l,
                                 input int err, input int run, input int maj);
        check({tag, " cnt_g"},    int'(cnt_g),    g);
        check({tag, " cnt_e"},    int'(cnt_e),    e);
        check({tag, " cnt_l"},    int'(cnt_l),    l);
        check({tag, " cnt_err"},  int'(cnt_err),  err);
        check({tag, " max_run"},  int'(max_run),  run);
        check({tag, " majority"}, int'(majority), maj);
    endtask

    initial begin
        vecs[0] = '{{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100},
                    8, 0, 0, 0, 8, 1};
        vecs[1] = '{{3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100},
                    3, 2, 3, 0, 3, 0};
        vecs[2] = '{{3'b100, 3'b100, 3'b000, 3'b100, 3'b110, 3'b001, 3'b001, 3'b001},
                    3, 0, 3, 2, 3, 0};
        vecs[3] = '{{3'b010, 3'b010, 3'b010, 3'b001, 3'b111, 3'b010, 3'b100, 3'b001},
                    1, 4, 2, 1, 3, 2};
        vecs[4] = '{{3'b001, 3'b100, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b000},
                    1, 1, 5, 1, 2, 3};

        // Reset with en and in_valid asserted: nothing may start.
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; {G, E, L} = 3'b100; out_ready = 1'b0;
        step();
        step();
        check("rst in_ready", int'(in_ready), 0);
        check("rst out_valid", int'(out_valid), 0);
        check_summary("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        check("post-rst still idle", int'(in_ready), 0);
        step();
        check("collect after rst", int'(in_ready), 1);

        // Table of full windows, each drained immediately with en still high.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < WINDOW; i++) begin
                if (i == WINDOW - 1) check($sformatf("v%0d out_valid early", v), int'(out_valid), 0);
                put(vecs[v].smp[i]);
            end
            in_valid = 1'b0;
            check($sformatf("v%0d out_valid", v), int'(out_valid), 1);
            check($sformatf("v%0d in_ready", v), int'(in_ready), 0);
            check_summary($sformatf("v%0d", v), vecs[v].g, vecs[v].e, vecs[v].l,
                          vecs[v].err, vecs[v].run, vecs[v].maj);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("v%0d drained", v), int'(out_valid), 0);
            check($sformatf("v%0d recollect", v), int'(in_ready), 1);
        end

        // Backpressure: summary held while in_valid keeps offering samples.
        for (int i = 0; i < WINDOW; i++) put(3'b100);
        {G, E, L} = 3'b010;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d in_ready", c), int'(in_ready), 0);
            check($sformatf("bp%0d out_valid", c), int'(out_valid), 1);
            check($sformatf("bp%0d cnt_g", c), int'(cnt_g), 8);
            check($sformatf("bp%0d cnt_e", c), int'(cnt_e), 0);
            step();
        end
        {G, E, L} = 3'b001;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp drained", int'(out_valid), 0);
        check("bp cleared cnt_l", int'(cnt_l), 0);
        // out_ready already high when the window fills: transfer on the first REPORT edge.
        for (int i = 0; i < WINDOW; i++) put(3'b010);
        in_valid = 1'b0;
        check("pre-ready out_valid", int'(out_valid), 1);
        check_summary("after bp", 0, 8, 0, 0, 8, 2);
        step();
        out_ready = 1'b0;
        check("pre-ready drained", int'(out_valid), 0);

        // Reset mid-window after 5 accepts.
        for (int i = 0; i < 5; i++) put(3'b001);
        check("mid cnt_l", int'(cnt_l), 5);
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        check("mid rst in_ready", int'(in_ready), 0);
        check("mid rst out_valid", int'(out_valid), 0);
        check_summary("mid rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        en  = 1'b0;
        step();
        check("idle holds with en=0", int'(in_ready), 0);
        en = 1'b1;
        step();
        check("collect after en", int'(in_ready), 1);

        // Window completed with en low at the handshake returns to IDLE.
        for (int i = 0; i < WINDOW; i++) put(3'b100);
        in_valid  = 1'b0;
        en        = 1'b0;
        out_ready = 1'b1;
        check("en0 out_valid", int'(out_valid), 1);
        step();
        out_ready = 1'b0;
        check("en0 drained", int'(out_valid), 0);
        check("en0 idle", int'(in_ready), 0);
        in_valid = 1'b1;
        step();
        step();
        check("en0 idle stays", int'(in_ready), 0);
        check("en0 nothing counted", int'(cnt_g), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_result_window.md
# cmp_result_window

Windowed result monitor that sits directly downstream of the 3-bit signed/unsigned comparator. It accepts one comparator result (G, E, L) per valid cycle and collects results in fixed-size windows. For each window it counts the greater, equal, less and malformed results, tracks the longest run of identical results, and presents a summary over a valid/ready handshake. Input is back-pressured while a summary is pending.

## Interface
- WINDOW, 8, number of accepted samples per window (1 ≤ WINDOW < 2^CNT_W)
- CNT_W, 4, width of every count and run output
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  enables collection; sampled only in IDLE and at report completion
- in_valid  in  1  G/E/L carry a result this cycle
- in_ready  out  1  block accepts a sample this cycle
- G  in  1  comparator "a > b"
- E  in  1  comparator "a = b"
- L  in  1  comparator "a < b"
- out_valid  out  1  summary outputs hold a complete window
- out_ready  in  1  consumer takes the summary
- cnt_g, cnt_e, cnt_l  out  CNT_W each  per-class counts for the window
- cnt_err  out  CNT_W  samples where G+E+L ≠ 1
- max_run  out  CNT_W  longest run of consecutive identical valid results
- majority  out  2  00 = tie or none, 01 = G, 10 = E, 11 = L

## Operation
- The FSM has three states: IDLE, COLLECT and REPORT. Reset enters IDLE.
- IDLE: in_ready=0, out_valid=0. When en=1, the FSM moves to COLLECT on the next edge, with all counters zeroed.
- COLLECT: in_ready=1. A sample is accepted on an edge where in_valid && in_ready.
- Classifying an accepted sample:
  - Exactly one of G/E/L is high: the matching count increments.
  - Otherwise (000, 110, 111, …): cnt_err increments and no class count changes.
- Run tracking, using an internal prev result and a cur_run register:
  - A valid sample equal to prev: cur_run+1.
  - A valid sample different from prev, or the first valid sample after an error or window start: cur_run=1.
  - An error sample: cur_run=0 and prev is cleared.
  - max_run = max(max_run, new cur_run), updated on the same edge.
- On the edge that accepts the WINDOW-th sample, the FSM enters REPORT. The final sample is included in the summary.
- REPORT: in_ready=0 and out_valid=1. All summary outputs are held stable until the handshake.
- majority is the class with the strictly largest count. Ties at the top, or all counts zero, give 00. It is combinational from the registered counts and is valid whenever out_valid=1.
- On an edge with out_valid && out_ready, all counts, run state and prev clear.
  - en=1: the FSM goes to COLLECT.
  - en=0: the FSM goes to IDLE.
- en is ignored during COLLECT. A window that has started always completes.
- Counts cannot overflow because WINDOW < 2^CNT_W. No saturation logic is needed.
- The S input of the comparator does not reach this block. Signedness is already resolved in G/E/L.

## Timing
- Reset values: in_ready=0, out_valid=0, all counts=0, max_run=0, majority=00, state IDLE.
- rst takes effect in any state and discards partial windows and pending reports.
- IDLE→COLLECT: 1 cycle after en is seen high. in_ready rises in the cycle after that edge.
- Latency: out_valid rises in the cycle after the edge that accepts the last sample.
- Best-case throughput is WINDOW samples per WINDOW+1 cycles, because REPORT lasts at least one cycle.
- out_ready may be high before out_valid rises. The transfer then completes on the first edge of REPORT.
- in_valid while in_ready=0: the sample is neither accepted nor counted. Upstream must hold or drop it.
- out_valid never drops without a handshake, except on rst.
- There is no combinational path from in_valid or out_ready to in_ready or out_valid. Both are registered state decodes.

## Test plan
- Reset: assert rst for 2 cycles with en=1 and in_valid=1 → during reset in_ready=0, out_valid=0 and every count is 0. COLLECT begins 1 cycle after rst falls.
- Uniform window: WINDOW=8, 8 accepted G=1 samples → cnt_g=8, cnt_e=0, cnt_l=0, cnt_err=0, max_run=8, majority=01. out_valid rises the cycle after the 8th accept.
- Mixed tie: the sequence G,G,E,L,L,L,E,G → cnt_g=3, cnt_e=2, cnt_l=3, max_run=3, majority=00.
- Malformed inputs: G,G,{000},G,{110},L,L,L → cnt_g=3, cnt_l=3, cnt_err=2, max_run=3 (the error breaks the G run), majority=00.
- Backpressure: after the window fills, hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and the summary is stable throughout. The next window counts only samples accepted after the handshake.
- Reset mid-window and en=0 at report: rst after 5 accepted samples → all outputs at reset values, state IDLE. Separately, complete a window with en=0 at the handshake → the FSM returns to IDLE and in_ready stays 0.
